// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: operand forwarding, load-use stalls,
// branch flushes and memory-wait stalls with a sticky timeout and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       idRs1,
  input  logic [3:0]       idRs2,
  input  logic             idUsesRs1,
  input  logic             idUsesRs2,
  input  logic             exRegWe,
  input  logic             exWriteRegFromAlu,
  input  logic [3:0]       exRegToWrite,
  input  logic             memRegWe,
  input  logic [3:0]       memRegToWrite,
  input  logic             exPcWe,
  input  logic             memReq,
  input  logic             memReady,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount
);

  localparam int unsigned WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic load_use_c;
  logic stall_fd_c, stall_em_c, flush_d_c, flush_e_c;

  // Execute-stage ALU result wins over the older memory-stage result.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [3:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && exRegWe && exWriteRegFromAlu && (exRegToWrite == rs)) begin
      sel = 2'b01;
    end else if (uses && memRegWe && (memRegToWrite == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    fwdA = fwd_sel(idUsesRs1, idRs1);
    fwdB = fwd_sel(idUsesRs2, idRs2);
  end

  assign load_use_c = exRegWe && !exWriteRegFromAlu &&
                      ((idUsesRs1 && (exRegToWrite == idRs1)) ||
                       (idUsesRs2 && (exRegToWrite == idRs2)));

  // Next state and control; memory stall outranks branch flush outranks load-use.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_fd_c = 1'b0;
    stall_em_c = 1'b0;
    flush_d_c  = 1'b0;
    flush_e_c  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memReq && !memReady) begin
          stall_fd_c = 1'b1;
          stall_em_c = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else if (exPcWe) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
          state_d   = ST_FLUSH;
        end else if (load_use_c) begin
          stall_fd_c = 1'b1;
          flush_e_c  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (memReady) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          stall_fd_c = 1'b1;
          stall_em_c = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_FLUSH: begin
        flush_d_c = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control outputs are forced quiet while reset is held.
  always_comb begin
    stallF = reset & stall_fd_c;
    stallD = reset & stall_fd_c;
    stallE = reset & stall_em_c;
    stallM = reset & stall_em_c;
    flushD = reset & flush_d_c;
    flushE = reset & flush_e_c;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign memTimeout = timeout_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: forwarding table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 15;
  localparam int unsigned CW = 5;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    idRs1, idRs2, exRegToWrite, memRegToWrite;
  logic          idUsesRs1, idUsesRs2, exRegWe, exWriteRegFromAlu, memRegWe;
  logic          exPcWe, memReq, memReady;
  logic [1:0]    fwdA, fwdB;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, memTimeout;
  logic [CW-1:0] stallCount;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRegWe(exRegWe), .exWriteRegFromAlu(exWriteRegFromAlu), .exRegToWrite(exRegToWrite),
    .memRegWe(memRegWe), .memRegToWrite(memRegToWrite), .exPcWe(exPcWe),
    .memReq(memReq), .memReady(memReady),
    .fwdA(fwdA), .fwdB(fwdB), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE), .memTimeout(memTimeout),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: cycles spent waiting on memory (0 = not waiting),
  // pending second branch-bubble cycle, sticky timeout and stall-cycle tally.
  int wait_n     = 0;
  bit flush_tail = 1'b0;
  bit m_to       = 1'b0;
  int m_cnt      = 0;
  bit e_sf;

  typedef struct packed {
    logic [3:0] rs1, rs2;
    logic       u1, u2, exwe, exalu;
    logic [3:0] exrd;
    logic       mwe;
    logic [3:0] mrd;
    logic [1:0] ea, eb;
  } fvec_t;

  fvec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] ref_fwd(input bit uses, input logic [3:0] rs);
    if (uses && exRegWe && exWriteRegFromAlu && exRegToWrite == rs) return 2'b01;
    if (uses && memRegWe && memRegToWrite == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
    exRegWe = 0; exWriteRegFromAlu = 0; exRegToWrite = 0;
    memRegWe = 0; memRegToWrite = 0; exPcWe = 0; memReq = 0; memReady = 0;
  endtask

  // Wait for the sampling edge and compare every output to the model.
  task automatic check_now();
    bit sf, se, fd, fe, lu;
    logic [10:0] exp_v;
    @(negedge clk);
    sf = 0; se = 0; fd = 0; fe = 0;
    lu = exRegWe && !exWriteRegFromAlu &&
         ((idUsesRs1 && exRegToWrite == idRs1) || (idUsesRs2 && exRegToWrite == idRs2));
    if (reset) begin
      if (wait_n > 0) begin
        if (!memReady && wait_n != TO) begin sf = 1; se = 1; end
      end else if (flush_tail) begin
        fd = 1;
      end else if (memReq && !memReady) begin
        sf = 1; se = 1;
      end else if (exPcWe) begin
        fd = 1; fe = 1;
      end else if (lu) begin
        sf = 1; fe = 1;
      end
    end
    e_sf = sf;
    exp_v = {ref_fwd(idUsesRs1, idRs1), ref_fwd(idUsesRs2, idRs2),
             sf, sf, se, se, fd, fe, reset ? m_to : 1'b0};
    chk("outputs{fwdA,fwdB,sF,sD,sE,sM,fD,fE,to}",
        {fwdA, fwdB, stallF, stallD, stallE, stallM, flushD, flushE, memTimeout}, exp_v);
    chk("stallCount", stallCount, reset ? m_cnt : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      wait_n = 0; flush_tail = 0; m_to = 0; m_cnt = 0;
    end else begin
      if (e_sf && m_cnt < CNT_MAX) m_cnt++;
      if (wait_n > 0) begin
        if (memReady) wait_n = 0;
        else if (wait_n == TO) begin wait_n = 0; m_to = 1; end
        else wait_n++;
      end else if (flush_tail) flush_tail = 0;
      else if (memReq && !memReady) wait_n = 1;
      else if (exPcWe) flush_tail = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    check_now(); tick();
    reset = 1;
  endtask

  initial begin
    int cyc;
    e_sf = 0;
    clear_inputs();
    reset = 0;
    tick(); tick();
    // Forwarding remains live while reset is held.
    exRegWe = 1; exWriteRegFromAlu = 1; exRegToWrite = 3; idRs1 = 3; idUsesRs1 = 1;
    memReq = 1;
    check_now();
    chk("fwdA in reset", fwdA, 2'b01);
    chk("stalls in reset", {stallF, stallE, flushD, flushE}, 4'b0000);
    chk("reset memTimeout", memTimeout, 1'b0);
    tick();
    clear_inputs();
    reset = 1;

    tbl[0] = '{4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 2'b01, 2'b00};
    tbl[1] = '{4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 2'b10, 2'b00};
    tbl[2] = '{4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 2'b00, 2'b00};
    tbl[3] = '{4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 4'd7, 2'b01, 2'b01};
    tbl[4] = '{4'd2, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 1'b1, 4'd2, 2'b10, 2'b01};
    tbl[5] = '{4'd4, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 4'd4, 2'b10, 2'b10};
    tbl[6] = '{4'd1, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 4'd1, 2'b00, 2'b01};
    tbl[7] = '{4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 4'd0, 2'b10, 2'b10};
    for (int i = 0; i < 8; i++) begin
      idRs1 = tbl[i].rs1; idRs2 = tbl[i].rs2; idUsesRs1 = tbl[i].u1; idUsesRs2 = tbl[i].u2;
      exRegWe = tbl[i].exwe; exWriteRegFromAlu = tbl[i].exalu; exRegToWrite = tbl[i].exrd;
      memRegWe = tbl[i].mwe; memRegToWrite = tbl[i].mrd;
      check_now();
      chk($sformatf("tbl%0d fwdA", i), fwdA, tbl[i].ea);
      chk($sformatf("tbl%0d fwdB", i), fwdB, tbl[i].eb);
      tick();
    end

    // Load-use: one-cycle stall with execute bubble.
    do_reset();
    exWriteRegFromAlu = 0; exRegWe = 1; exRegToWrite = 5; idRs2 = 5; idUsesRs2 = 1;
    check_now();
    chk("loaduse sF/sD/fE/sE", {stallF, stallD, flushE, stallE}, 4'b1110);
    tick();
    clear_inputs();
    check_now();
    chk("loaduse release", stallF, 1'b0);
    chk("loaduse stallCount", stallCount, 1);
    tick();

    // Branch: two-cycle penalty.
    do_reset();
    exPcWe = 1;
    check_now();
    chk("branch c0 flush", {flushD, flushE}, 2'b11);
    tick();
    exPcWe = 0;
    check_now();
    chk("branch c1 flush", {flushD, flushE}, 2'b10);
    tick();
    check_now();
    chk("branch c2 flush", {flushD, flushE}, 2'b00);
    tick();

    // Memory wait of four cycles.
    do_reset();
    memReq = 1; memReady = 0;
    for (int i = 0; i < 4; i++) begin
      check_now();
      chk($sformatf("memwait c%0d stalls", i), {stallF, stallD, stallE, stallM}, 4'hf);
      tick();
    end
    memReady = 1;
    check_now();
    chk("memwait release stalls", {stallF, stallD, stallE, stallM}, 4'h0);
    tick();
    clear_inputs();
    check_now();
    chk("memwait memTimeout", memTimeout, 1'b0);
    chk("memwait stallCount", stallCount, 4);
    tick();

    // Timeout after TIMEOUT stalled cycles; sticky until reset.
    do_reset();
    memReq = 1; memReady = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      check_now();
      if (!stallF) break;
      cyc++;
      tick();
    end
    chk("timeout stall cycles", cyc, TO);
    tick();
    memReq = 0;
    check_now();
    chk("timeout set", memTimeout, 1'b1);
    tick();
    exPcWe = 1;
    for (int i = 0; i < 5; i++) begin check_now(); tick(); end
    exPcWe = 0;
    check_now();
    chk("timeout sticky", memTimeout, 1'b1);
    tick();
    do_reset();
    check_now();
    chk("timeout cleared by reset", memTimeout, 1'b0);
    tick();

    // Branch coincident with memory stall is deferred until release.
    exPcWe = 1; memReq = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      check_now();
      chk($sformatf("collide c%0d", i), {stallF, stallM, flushD, flushE}, 4'b1100);
      tick();
    end
    memReady = 1;
    check_now();
    chk("collide release", {stallF, flushD, flushE}, 3'b000);
    tick();
    memReq = 0; memReady = 0;
    check_now();
    chk("collide deferred flush", {flushD, flushE}, 2'b11);
    tick();
    exPcWe = 0;
    check_now();
    chk("collide flush tail", {flushD, flushE}, 2'b10);
    tick();
    memReq = 1;
    check_now(); tick();
    check_now();
    chk("pre-reset in wait", stallF, 1'b1);
    tick();
    reset = 0;
    #1;
    chk("async reset stalls", {stallF, stallD, stallE, stallM}, 4'h0);
    check_now();
    tick();
    reset = 1; memReq = 0; exPcWe = 1;
    check_now();
    chk("run after reset", {stallF, flushD, flushE}, 3'b011);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      idRs1 = 4'($urandom_range(0, 3)); idRs2 = 4'($urandom_range(0, 3));
      exRegToWrite = 4'($urandom_range(0, 3)); memRegToWrite = 4'($urandom_range(0, 3));
      idUsesRs1 = 1'($urandom_range(0, 1)); idUsesRs2 = 1'($urandom_range(0, 1));
      exRegWe = 1'($urandom_range(0, 1)); exWriteRegFromAlu = 1'($urandom_range(0, 1));
      memRegWe = 1'($urandom_range(0, 1));
      exPcWe = ($urandom_range(0, 5) == 0);
      if ((i % 400) < 20) begin
        memReq = 1; memReady = 0;
      end else begin
        memReq = ($urandom_range(0, 3) == 0);
        memReady = ($urandom_range(0, 2) != 0);
      end
      reset = ($urandom_range(0, 299) != 0);
      check_now();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
